// File: rtl/softmax_pe.sv
// Softmax array processing element: valid/ready operand and result streams, local
// accumulator with saturating ALU, scratch registers and a restoring unsigned divider.
module softmax_pe #(
  parameter int BITWIDTH  = 16,
  parameter int REG_DEPTH = 4,
  parameter int ADDR_W    = $clog2(REG_DEPTH)
) (
  input  logic                clk,
  input  logic                reset,
  input  logic                in_valid,
  output logic                in_ready,
  input  logic [2:0]          op_code,
  input  logic [BITWIDTH-1:0] input_left,
  input  logic [ADDR_W-1:0]   reg_addr,
  output logic [BITWIDTH-1:0] output_right,
  output logic                out_valid,
  input  logic                out_ready,
  output logic [BITWIDTH-1:0] output_down,
  output logic                div_by_zero,
  output logic                busy
);
  localparam int CNT_W = $clog2(BITWIDTH);
  localparam logic [CNT_W-1:0]    CNT_INIT = CNT_W'(BITWIDTH - 1);
  localparam logic [BITWIDTH-1:0] ONE      = BITWIDTH'(1);
  localparam logic [BITWIDTH-1:0] MAX_POS  = {1'b0, {(BITWIDTH-1){1'b1}}};
  localparam logic [BITWIDTH-1:0] MIN_NEG  = {1'b1, {(BITWIDTH-1){1'b0}}};

  localparam logic [2:0] OP_MAX = 3'd0, OP_EXP2 = 3'd1, OP_ADD = 3'd2, OP_SUB = 3'd3,
                         OP_DIV = 3'd4, OP_LDA = 3'd5, OP_STORE = 3'd6, OP_LOAD = 3'd7;

  typedef enum logic {S_IDLE, S_DIV} state_t;
  state_t state_q, state_d;

  logic [BITWIDTH-1:0] acc;
  logic [BITWIDTH-1:0] regs [REG_DEPTH];
  logic [BITWIDTH-1:0] dvsr, quo, rem;
  logic [CNT_W-1:0]    cnt;
  logic                accept;

  assign in_ready    = (state_q == S_IDLE) && (!out_valid || out_ready);
  assign accept      = in_valid && in_ready;
  assign busy        = (state_q == S_DIV);
  assign output_down = acc;

  always_ff @(posedge clk) begin
    if (reset) state_q <= S_IDLE;
    else       state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      S_IDLE: if (accept && op_code == OP_DIV && input_left != '0) state_d = S_DIV;
      S_DIV:  if (cnt == '0) state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  // One restoring step: shift the next dividend bit into the partial remainder.
  logic [BITWIDTH:0]   shifted, trial;
  logic                q_bit;
  logic [BITWIDTH-1:0] rem_nxt, quo_nxt;
  always_comb begin
    shifted = {rem, quo[BITWIDTH-1]};
    trial   = shifted - {1'b0, dvsr};
    q_bit   = !trial[BITWIDTH];
    rem_nxt = q_bit ? trial[BITWIDTH-1:0] : shifted[BITWIDTH-1:0];
    quo_nxt = {quo[BITWIDTH-2:0], q_bit};
  end

  function automatic logic [BITWIDTH-1:0] sat(input logic [BITWIDTH:0] x);
    if (x[BITWIDTH] != x[BITWIDTH-1]) return x[BITWIDTH] ? MIN_NEG : MAX_POS;
    return x[BITWIDTH-1:0];
  endfunction

  logic [BITWIDTH:0]   add_ext, sub_ext;
  logic [BITWIDTH-1:0] alu_res;
  always_comb begin
    add_ext = {acc[BITWIDTH-1], acc} + {input_left[BITWIDTH-1], input_left};
    sub_ext = {acc[BITWIDTH-1], acc} - {input_left[BITWIDTH-1], input_left};
    alu_res = acc;
    case (op_code)
      OP_MAX:  alu_res = ($signed(input_left) > $signed(acc)) ? input_left : acc;
      OP_EXP2: begin
        if (input_left[BITWIDTH-1])                        alu_res = '0;
        else if (input_left >= BITWIDTH'(BITWIDTH - 1))    alu_res = MAX_POS;
        else                                               alu_res = ONE << input_left;
      end
      OP_ADD:  alu_res = sat(add_ext);
      OP_SUB:  alu_res = sat(sub_ext);
      OP_LDA:  alu_res = input_left;
      OP_LOAD: alu_res = regs[reg_addr];
      default: alu_res = acc;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      acc          <= '0;
      output_right <= '0;
      out_valid    <= 1'b0;
      div_by_zero  <= 1'b0;
      dvsr         <= '0;
      quo          <= '0;
      rem          <= '0;
      cnt          <= '0;
      for (int i = 0; i < REG_DEPTH; i++) regs[i] <= '0;
    end else if (accept) begin
      output_right <= input_left;
      out_valid    <= 1'b1;
      case (op_code)
        OP_DIV: begin
          if (input_left == '0) begin
            acc         <= '1;
            div_by_zero <= 1'b1;
          end else begin
            dvsr      <= input_left;
            quo       <= acc;
            rem       <= '0;
            cnt       <= CNT_INIT;
            out_valid <= 1'b0;
          end
        end
        OP_STORE: regs[reg_addr] <= acc;
        default: begin
          acc <= alu_res;
          if (op_code == OP_LDA) div_by_zero <= 1'b0;
        end
      endcase
    end else if (state_q == S_DIV) begin
      rem <= rem_nxt;
      quo <= quo_nxt;
      cnt <= cnt - 1'b1;
      if (cnt == '0) begin
        acc       <= quo_nxt;
        out_valid <= 1'b1;
      end
    end else if (out_ready) begin
      out_valid <= 1'b0;
    end
  end
endmodule

// File: tb/tb_softmax_pe.sv
// Directed plus randomized bench for softmax_pe against an arithmetic reference model.
module tb_softmax_pe;
  localparam int BW = 16;
  localparam logic [2:0] MAX = 0, EXP2 = 1, ADD = 2, SUB = 3, DIV = 4, LDA = 5, STORE = 6, LOAD = 7;

  logic          clk = 0, reset = 1, in_valid = 0, out_ready = 1;
  logic          in_ready, out_valid, div_by_zero, busy;
  logic [2:0]    op_code = 0;
  logic [BW-1:0] input_left = 0, output_right, output_down;
  logic [1:0]    reg_addr = 0;

  softmax_pe #(.BITWIDTH(BW), .REG_DEPTH(4)) dut (
    .clk(clk), .reset(reset), .in_valid(in_valid), .in_ready(in_ready),
    .op_code(op_code), .input_left(input_left), .reg_addr(reg_addr),
    .output_right(output_right), .out_valid(out_valid), .out_ready(out_ready),
    .output_down(output_down), .div_by_zero(div_by_zero), .busy(busy));

  always #5 clk = ~clk;

  int total = 0, bad = 0;
  logic [BW-1:0] acc_m, regs_m [4];
  logic          dbz_m;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk); #1;
  endtask

  task automatic model_reset();
    acc_m = 0; dbz_m = 0;
    for (int i = 0; i < 4; i++) regs_m[i] = 0;
  endtask

  // Reference semantics written as plain integer arithmetic.
  task automatic model(input logic [2:0] op, input logic [BW-1:0] a, input logic [1:0] ad);
    int sa, sacc, s;
    sa = $signed(a); sacc = $signed(acc_m);
    case (op)
      MAX:  acc_m = (sa > sacc) ? a : acc_m;
      EXP2: acc_m = (sa < 0) ? 16'd0 : (sa >= BW - 1) ? 16'd32767 : 16'(1 << sa);
      ADD, SUB: begin
        s = (op == ADD) ? sacc + sa : sacc - sa;
        if (s > 32767) s = 32767;
        if (s < -32768) s = -32768;
        acc_m = 16'(s);
      end
      DIV: if (a == 0) begin acc_m = 16'hFFFF; dbz_m = 1; end
           else acc_m = 16'(int'(acc_m) / int'(a));
      LDA:   begin acc_m = a; dbz_m = 0; end
      STORE: regs_m[ad] = acc_m;
      default: acc_m = regs_m[ad];
    endcase
  endtask

  task automatic send(input logic [2:0] op, input logic [BW-1:0] a, input logic [1:0] ad);
    int n = 0;
    while (!in_ready && n < 50) begin step(); n++; end
    check("ready_wait", {31'd0, in_ready}, 32'd1);
    in_valid = 1; op_code = op; input_left = a; reg_addr = ad;
    @(posedge clk); #1;
    in_valid = 0; op_code = 3'($urandom); input_left = 16'($urandom); reg_addr = 2'($urandom);
    model(op, a, ad);
    if (op == DIV && a != 0) begin
      check("div_busy", {31'd0, busy}, 32'd1);
      check("div_inready", {31'd0, in_ready}, 32'd0);
      repeat (BW - 1) step();
      check("div_early", {31'd0, out_valid}, 32'd0);
      step();
    end
    check("out_valid", {31'd0, out_valid}, 32'd1);
    check("out_down", {16'd0, output_down}, {16'd0, acc_m});
    check("out_right", {16'd0, output_right}, {16'd0, a});
    check("dbz", {31'd0, div_by_zero}, {31'd0, dbz_m});
    check("busy_low", {31'd0, busy}, 32'd0);
  endtask

  initial begin
    logic [BW-1:0] held;
    logic          stale;
    model_reset();
    step(); step();
    reset = 0;
    check("rst_valid", {31'd0, out_valid}, 32'd0);
    check("rst_down", {16'd0, output_down}, 32'd0);
    check("rst_right", {16'd0, output_right}, 32'd0);
    check("rst_dbz", {31'd0, div_by_zero}, 32'd0);
    check("rst_busy", {31'd0, busy}, 32'd0);
    check("rst_ready", {31'd0, in_ready}, 32'd1);

    send(LDA, 5, 0);
    step();
    check("one_cycle_valid", {31'd0, out_valid}, 32'd0);

    // softmax-style sequence
    send(LDA, 3, 0); send(EXP2, 3, 0); check("exp2_8", {16'd0, output_down}, 32'd8);
    send(STORE, 0, 1); send(LDA, 24, 0); send(DIV, 8, 0);
    check("div_3", {16'd0, output_down}, 32'd3);
    send(LOAD, 0, 1); check("load_8", {16'd0, output_down}, 32'd8);

    // saturation and boundaries
    send(LDA, 16'd32767, 0); send(ADD, 1, 0); check("add_sat", {16'd0, output_down}, 32'h7FFF);
    send(LDA, 16'h8000, 0); send(SUB, 1, 0); check("sub_sat", {16'd0, output_down}, 32'h8000);
    send(LDA, -16'sd5, 0); send(MAX, 2, 0); check("max", {16'd0, output_down}, 32'd2);
    send(EXP2, 16'hFFFF, 0); check("exp2_neg", {16'd0, output_down}, 32'd0);
    send(EXP2, 20, 0); check("exp2_sat", {16'd0, output_down}, 32'h7FFF);
    send(EXP2, 15, 0); send(EXP2, 14, 0); check("exp2_14", {16'd0, output_down}, 32'h4000);

    // divide by zero is sticky until LDA
    send(DIV, 0, 0); check("dbz_res", {16'd0, output_down}, 32'hFFFF);
    send(ADD, 1, 0); send(MAX, 7, 0);
    check("dbz_sticky", {31'd0, div_by_zero}, 32'd1);
    send(LDA, 0, 0);
    check("dbz_clear", {31'd0, div_by_zero}, 32'd0);

    // backpressure
    send(LDA, 100, 0); step();
    out_ready = 0;
    send(ADD, 7, 0);
    held = output_down;
    in_valid = 1; op_code = LDA; input_left = 999; reg_addr = 0;
    repeat (5) begin
      step();
      check("bp_hold", {16'd0, output_down}, {16'd0, held});
      check("bp_valid", {31'd0, out_valid}, 32'd1);
      check("bp_ready", {31'd0, in_ready}, 32'd0);
      check("bp_right", {16'd0, output_right}, 32'd7);
    end
    out_ready = 1;
    step();
    in_valid = 0;
    model(LDA, 999, 0);
    check("bp_next_valid", {31'd0, out_valid}, 32'd1);
    check("bp_next_down", {16'd0, output_down}, 32'd999);

    // random ops against the model
    for (int i = 0; i < 80; i++) begin
      logic [2:0]    op;
      logic [BW-1:0] a;
      op = 3'($urandom);
      a = 16'($urandom);
      if (op == EXP2) a = 16'($urandom_range(0, 22)) - 16'd2;
      if (op == DIV) a = ($urandom_range(0, 7) == 0) ? 16'd0 : 16'($urandom_range(1, 300));
      send(op, a, 2'($urandom));
    end

    // reset mid-divide
    send(LDA, 1000, 0);
    in_valid = 1; op_code = DIV; input_left = 7;
    step();
    in_valid = 0;
    repeat (3) step();
    reset = 1; step(); reset = 0;
    model_reset();
    check("mrst_valid", {31'd0, out_valid}, 32'd0);
    check("mrst_busy", {31'd0, busy}, 32'd0);
    check("mrst_acc", {16'd0, output_down}, 32'd0);
    check("mrst_ready", {31'd0, in_ready}, 32'd1);
    check("mrst_right", {16'd0, output_right}, 32'd0);
    stale = 0;
    repeat (20) begin step(); if (out_valid) stale = 1; end
    check("mrst_no_stale", {31'd0, stale}, 32'd0);
    send(ADD, 9, 0);
    check("post_rst_add", {16'd0, output_down}, 32'd9);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL timeout observed=running expected=finished");
    $fatal(1, "timeout");
  end
endmodule
